// File: rtl/multicycle_ctrl.sv
`default_nettype none
// multicycle_ctrl: IF/ID/EXE/MEM/WB sequencer driving the RFplusALU control inputs.
// Owns PC, IR and PSW {N,Z,C}; stalls in IF and MEM until MemReady.
module multicycle_ctrl #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [15:0]     Instr,
  input  logic            MemReady,
  input  logic            C,
  input  logic            Z,
  input  logic            N,
  output logic [PC_W-1:0] PC,
  output logic [10:0]     Ins,
  output logic            MemRd,
  output logic            MemWr,
  output logic            WBRF,
  output logic            WBresource,
  output logic            RBresource,
  output logic            OprandB,
  output logic            LI,
  output logic            ALUop,
  output logic            Flag,
  output logic            PSW_C,
  output logic            IllegalOp
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EXE  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [4:0] OP_ALU  = 5'b00000;
  localparam logic [4:0] OP_LHI  = 5'b00001;
  localparam logic [4:0] OP_LLI  = 5'b00010;
  localparam logic [4:0] OP_LDR  = 5'b00011;
  localparam logic [4:0] OP_STR  = 5'b00100;
  localparam logic [4:0] OP_B    = 5'b00101;
  localparam logic [4:0] OP_BZ   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11111;

  logic [2:0]      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic [2:0]      psw_q, psw_d;                 // {N,Z,C}
  logic [5:0]      ctrl_q, ctrl_d, ctrl_dec;     // {RBresource,OprandB,LI,ALUop,Flag,WBresource}
  logic [4:0]      opcode;
  logic            illegal;
  logic [PC_W-1:0] br_off;

  assign opcode = ir_q[15:11];
  assign br_off = {{(PC_W-8){ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    ctrl_dec = 6'b000000;
    illegal  = 1'b0;
    case (opcode)
      OP_ALU:                ctrl_dec = {3'b000, ir_q[1:0], 1'b0};
      OP_LHI:                ctrl_dec = 6'b101000;
      OP_LLI:                ctrl_dec = 6'b000000;
      OP_LDR:                ctrl_dec = 6'b110001;
      OP_STR:                ctrl_dec = 6'b110000;
      OP_B, OP_BZ, OP_HALT:  ctrl_dec = 6'b000000;
      default:               illegal  = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:  if (MemReady) state_d = S_ID;
      S_ID: begin
        if (opcode == OP_HALT) state_d = S_HALT;
        else if (illegal)      state_d = S_IF;
        else                   state_d = S_EXE;
      end
      S_EXE: begin
        case (opcode)
          OP_LDR, OP_STR: state_d = S_MEM;
          OP_B, OP_BZ:    state_d = S_IF;
          default:        state_d = S_WB;
        endcase
      end
      S_MEM: if (MemReady) state_d = (opcode == OP_LDR) ? S_WB : S_IF;
      S_WB:   state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  always_comb begin
    MemRd     = 1'b0;
    MemWr     = 1'b0;
    WBRF      = 1'b0;
    IllegalOp = 1'b0;
    case (state_q)
      S_IF:  MemRd     = Reset;
      S_ID:  IllegalOp = illegal;
      S_MEM: begin
        MemRd = (opcode == OP_LDR);
        MemWr = (opcode == OP_STR);
      end
      S_WB:  WBRF      = 1'b1;
      default: ;
    endcase
  end

  // Decode fields latch on ID exit and clear whenever the FSM returns to IF or HALT.
  always_comb begin
    ir_d   = ir_q;
    pc_d   = pc_q;
    psw_d  = psw_q;
    ctrl_d = ctrl_q;
    if (state_q == S_IF && MemReady) begin
      ir_d = Instr;
      pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
    end
    if (state_q == S_EXE) begin
      if (opcode == OP_ALU) psw_d = {N, Z, C};
      if (opcode == OP_B || (opcode == OP_BZ && psw_q[1])) pc_d = pc_q + br_off;
    end
    if (state_d == S_IF || state_d == S_HALT) ctrl_d = 6'b000000;
    else if (state_q == S_ID)                 ctrl_d = ctrl_dec;
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pc_q   <= RESET_PC;
      ir_q   <= 16'h0000;
      psw_q  <= 3'b000;
      ctrl_q <= 6'b000000;
    end else begin
      pc_q   <= pc_d;
      ir_q   <= ir_d;
      psw_q  <= psw_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign PC    = pc_q;
  assign Ins   = ir_q[10:0];
  assign PSW_C = psw_q[0];
  assign {RBresource, OprandB, LI, ALUop, Flag, WBresource} = ctrl_q;

endmodule
`default_nettype wire
